// File: rtl/dino_pkg.sv
// Shared types and constants for the dino score counter slice.
package dino_pkg;

  typedef logic [3:0][3:0] bcd4_t;

  typedef enum logic {
    RUN    = 1'b0,
    FROZEN = 1'b1
  } score_state_e;

  localparam logic [15:0] SCORE_MAX_BCD = 16'h9999;

endpackage

// File: rtl/dino_score_counter_bcd_incr.sv
// Combinational 4-digit BCD +1; carry_o is set only when the input is 9999.
module bcd_incr
  import dino_pkg::*;
(
  input  bcd4_t val_i,
  output bcd4_t val_o,
  output logic  carry_o
);

  logic carry;

  always_comb begin
    carry = 1'b1;
    val_o = val_i;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (val_i[i] == 4'd9) begin
          val_o[i] = 4'd0;
        end else begin
          val_o[i] = val_i[i] + 4'd1;
          carry    = 1'b0;
        end
      end
    end
    carry_o = carry;
  end

endmodule

// File: rtl/dino_score_counter.sv
// 4-digit BCD game score with prescaled ticks, saturation, blanking and display mux.
// DINO_HIGH_SCORE_EN adds the high-score register, commit on freeze and show_high_i mux.
module dino_score_counter
  import dino_pkg::*;
#(
  parameter int unsigned TICKS_PER_POINT = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tick_i,
  input  logic        freeze_i,
  input  logic        clear_i,
  input  logic        show_high_i,
  output logic        digit0_en_o,
  output logic        digit1_en_o,
  output logic        digit2_en_o,
  output logic        digit3_en_o,
  output logic [3:0]  digit0_o,
  output logic [3:0]  digit1_o,
  output logic [3:0]  digit2_o,
  output logic [3:0]  digit3_o,
  output logic [15:0] score_bcd_o,
  output logic [15:0] high_bcd_o,
  output logic        sat_o,
  output logic        running_o
);

  localparam logic [7:0] PRE_LAST = 8'(TICKS_PER_POINT - 1);

  score_state_e state_q;
  bcd4_t        score_q, score_d;
  bcd4_t        high_q;
  logic [7:0]   pre_q;
  logic         score_carry;
  bcd4_t        disp;

  bcd_incr u_incr (
    .val_i   (score_q),
    .val_o   (score_d),
    .carry_o (score_carry)
  );

  // Carry-out of +1 only happens at 9999, which doubles as the saturation flag.
  assign sat_o     = score_carry;
  assign running_o = (state_q == RUN);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RUN;
      score_q <= '0;
      pre_q   <= '0;
    end else if (clear_i) begin
      state_q <= RUN;
      score_q <= '0;
      pre_q   <= '0;
    end else if (freeze_i) begin
      state_q <= FROZEN;
    end else if (tick_i && state_q == RUN && !score_carry) begin
      if (pre_q == PRE_LAST) begin
        pre_q   <= '0;
        score_q <= score_d;
      end else begin
        pre_q <= pre_q + 8'd1;
      end
    end
  end

`ifdef DINO_HIGH_SCORE_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      high_q <= '0;
    end else if (!clear_i && freeze_i && state_q == RUN && score_q > high_q) begin
      high_q <= score_q;
    end
  end

  assign disp = show_high_i ? high_q : score_q;
`else
  logic unused_show_high;

  assign high_q           = '0;
  assign unused_show_high = show_high_i;
  assign disp             = score_q;
`endif

  assign score_bcd_o = score_q;
  assign high_bcd_o  = high_q;

  assign digit0_o = disp[0];
  assign digit1_o = disp[1];
  assign digit2_o = disp[2];
  assign digit3_o = disp[3];

  // Blanked digits keep driving 0; only the enables drop.
  assign digit3_en_o = |disp[3];
  assign digit2_en_o = |{disp[3], disp[2]};
  assign digit1_en_o = |{disp[3], disp[2], disp[1]};
  assign digit0_en_o = 1'b1;

endmodule

// File: tb/tb_dino_score_counter.sv
// Bench for dino_score_counter: TICKS_PER_POINT=1 and =4 instances driven in lockstep.
module tb_dino_score_counter;

`ifdef DINO_HIGH_SCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  typedef logic [53:0] obs_t;

  typedef struct {
    bit          c, f, t, s;
    int          rep;
    logic [15:0] a, b, hi;
    bit          sat, run;
    logic [15:0] disp;
    logic [3:0]  en;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, tick, frz, clr, sh;

  logic [3:0]       en_a, en_b;
  logic [3:0][3:0]  dig_a, dig_b;
  logic [15:0]      score_a, score_b, high_a, high_b;
  logic             sat_a, sat_b, run_a, run_b;
  obs_t             obs_a, obs_b;

  dino_score_counter #(.TICKS_PER_POINT(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .freeze_i(frz), .clear_i(clr),
    .show_high_i(sh),
    .digit0_en_o(en_a[0]), .digit1_en_o(en_a[1]), .digit2_en_o(en_a[2]), .digit3_en_o(en_a[3]),
    .digit0_o(dig_a[0]), .digit1_o(dig_a[1]), .digit2_o(dig_a[2]), .digit3_o(dig_a[3]),
    .score_bcd_o(score_a), .high_bcd_o(high_a), .sat_o(sat_a), .running_o(run_a)
  );

  dino_score_counter #(.TICKS_PER_POINT(4)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .freeze_i(frz), .clear_i(clr),
    .show_high_i(sh),
    .digit0_en_o(en_b[0]), .digit1_en_o(en_b[1]), .digit2_en_o(en_b[2]), .digit3_en_o(en_b[3]),
    .digit0_o(dig_b[0]), .digit1_o(dig_b[1]), .digit2_o(dig_b[2]), .digit3_o(dig_b[3]),
    .score_bcd_o(score_b), .high_bcd_o(high_b), .sat_o(sat_b), .running_o(run_b)
  );

  assign obs_a = {score_a, high_a, sat_a, run_a, dig_a, en_a};
  assign obs_b = {score_b, high_b, sat_b, run_b, dig_b, en_b};

  localparam obs_t RST_OBS = {16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 4'b0001};

  int checks = 0;
  int errors = 0;

  // Reference model in plain integers.
  int   m_sc[2], m_pre[2], m_hi[2];
  bit   m_fz[2];
  int   m_tpp[2] = '{1, 4};
  obs_t exp_q[$];

  function automatic logic [15:0] to_bcd(input int v);
    logic [3:0] d3, d2, d1, d0;
    d3 = 4'(v / 1000);
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    return {d3, d2, d1, d0};
  endfunction

  function automatic obs_t model_obs(input int k, input bit shw);
    int         d;
    logic [3:0] en;
    d  = (HS && shw) ? m_hi[k] : m_sc[k];
    en = {d >= 1000, d >= 100, d >= 10, 1'b1};
    return {to_bcd(m_sc[k]), to_bcd(m_hi[k]), m_sc[k] == 9999, !m_fz[k], to_bcd(d), en};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sc[k] = 0; m_pre[k] = 0; m_hi[k] = 0; m_fz[k] = 1'b0;
    end
  endtask

  task automatic model_step(input bit c, input bit f, input bit t);
    for (int k = 0; k < 2; k++) begin
      if (c) begin
        m_sc[k] = 0; m_pre[k] = 0; m_fz[k] = 1'b0;
      end else if (f) begin
        if (!m_fz[k]) begin
          m_fz[k] = 1'b1;
          if (HS && m_sc[k] > m_hi[k]) m_hi[k] = m_sc[k];
        end
      end else if (t && !m_fz[k] && m_sc[k] < 9999) begin
        if (m_pre[k] == m_tpp[k] - 1) begin
          m_pre[k] = 0;
          m_sc[k]  = m_sc[k] + 1;
        end else begin
          m_pre[k] = m_pre[k] + 1;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit c, input bit f, input bit t, input bit s);
    obs_t e;
    clr = c; frz = f; tick = t; sh = s;
    @(posedge clk);
    model_step(c, f, t);
    exp_q.push_back(model_obs(0, s));
    exp_q.push_back(model_obs(1, s));
    @(negedge clk);
    e = exp_q.pop_front();
    chk("sb_tpp1", 64'(obs_a), 64'(e));
    e = exp_q.pop_front();
    chk("sb_tpp4", 64'(obs_b), 64'(e));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clr = 1'b0; frz = 1'b0; tick = 1'b0; sh = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    chk("reset_tpp1", 64'(obs_a), 64'(RST_OBS));
    chk("reset_tpp4", 64'(obs_b), 64'(RST_OBS));
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input bit c, f, t, s, input int rep,
                              input logic [15:0] a, b, hi, input bit sat, run,
                              input logic [15:0] disp, input logic [3:0] en);
    vec_t v;
    v.c = c; v.f = f; v.t = t; v.s = s; v.rep = rep;
    v.a = a; v.b = b; v.hi = HS ? hi : 16'h0000; v.sat = sat; v.run = run;
    v.disp = disp; v.en = en;
    return v;
  endfunction

  vec_t vecs[20];

  initial begin
    vecs[0]  = mk(0,0,1,0,   12, 16'h0012, 16'h0003, 16'h0000, 0, 1, 16'h0012, 4'b0011);
    vecs[1]  = mk(1,0,0,0,    1, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0000, 4'b0001);
    vecs[2]  = mk(0,0,1,0,    9, 16'h0009, 16'h0002, 16'h0000, 0, 1, 16'h0009, 4'b0001);
    vecs[3]  = mk(1,0,0,0,    1, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0000, 4'b0001);
    vecs[4]  = mk(0,0,1,0,    4, 16'h0004, 16'h0001, 16'h0000, 0, 1, 16'h0004, 4'b0001);
    vecs[5]  = mk(0,0,1,0,  995, 16'h0999, 16'h0249, 16'h0000, 0, 1, 16'h0999, 4'b0111);
    vecs[6]  = mk(0,0,1,0,    1, 16'h1000, 16'h0250, 16'h0000, 0, 1, 16'h1000, 4'b1111);
    vecs[7]  = mk(1,0,0,0,    1, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0000, 4'b0001);
    vecs[8]  = mk(0,0,1,0,  150, 16'h0150, 16'h0037, 16'h0000, 0, 1, 16'h0150, 4'b0111);
    vecs[9]  = mk(0,1,1,0,    1, 16'h0150, 16'h0037, 16'h0150, 0, 0, 16'h0150, 4'b0111);
    vecs[10] = mk(0,0,1,0,    1, 16'h0150, 16'h0037, 16'h0150, 0, 0, 16'h0150, 4'b0111);
    vecs[11] = mk(0,0,0,1,    1, 16'h0150, 16'h0037, 16'h0150, 0, 0, 16'h0150, 4'b0111);
    vecs[12] = mk(1,0,0,0,    1, 16'h0000, 16'h0000, 16'h0150, 0, 1, 16'h0000, 4'b0001);
    vecs[13] = mk(0,0,1,0,   42, 16'h0042, 16'h0010, 16'h0150, 0, 1, 16'h0042, 4'b0011);
    vecs[14] = mk(0,1,0,0,    1, 16'h0042, 16'h0010, 16'h0150, 0, 0, 16'h0042, 4'b0011);
    vecs[15] = mk(0,0,0,1,    1, 16'h0042, 16'h0010, 16'h0150, 0, 0,
                  HS ? 16'h0150 : 16'h0042, HS ? 4'b0111 : 4'b0011);
    vecs[16] = mk(1,0,1,0,    1, 16'h0000, 16'h0000, 16'h0150, 0, 1, 16'h0000, 4'b0001);
    vecs[17] = mk(0,0,1,0, 9998, 16'h9998, 16'h2499, 16'h0150, 0, 1, 16'h9998, 4'b1111);
    vecs[18] = mk(0,0,1,0,    3, 16'h9999, 16'h2500, 16'h0150, 1, 1, 16'h9999, 4'b1111);
    vecs[19] = mk(0,1,0,0,    1, 16'h9999, 16'h2500, 16'h9999, 1, 0, 16'h9999, 4'b1111);

    do_reset();

    for (int i = 0; i < 20; i++) begin
      for (int r = 0; r < vecs[i].rep; r++) step(vecs[i].c, vecs[i].f, vecs[i].t, vecs[i].s);
      chk($sformatf("v%0d_score_tpp1", i), 64'(score_a), 64'(vecs[i].a));
      chk($sformatf("v%0d_score_tpp4", i), 64'(score_b), 64'(vecs[i].b));
      chk($sformatf("v%0d_high_tpp1", i),  64'(high_a),  64'(vecs[i].hi));
      chk($sformatf("v%0d_sat", i),        64'(sat_a),   64'(vecs[i].sat));
      chk($sformatf("v%0d_running", i),    64'(run_a),   64'(vecs[i].run));
      chk($sformatf("v%0d_display", i),    64'(dig_a),   64'(vecs[i].disp));
      chk($sformatf("v%0d_enables", i),    64'(en_a),    64'(vecs[i].en));
    end

    // Further ticks while frozen at 9999 change nothing.
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    chk("frozen_sat_hold", 64'(score_a), 64'h9999);

    // Zero-latency show_high mux: change the level and look before any edge.
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 1, 0);
    sh = 1'b1;
    #1;
    chk("show_high_comb", 64'(dig_a), HS ? 64'h9999 : 64'h0005);
    chk("high_after_5", 64'(high_a), HS ? 64'h9999 : 64'h0000);
    sh = 1'b0;
    #1;
    chk("show_cur_comb", 64'(dig_a), 64'h0005);

    // Mid-game reset wipes the high score too.
    do_reset();
    chk("reset_high", 64'(high_a), 64'h0000);
    step(0, 0, 1, 0);
    chk("post_reset_tick", 64'(score_a), 64'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dino_score_counter.md
# dino_score_counter

Maintains the running game score as a 4-digit BCD counter with optional high-score memory and feeds the 4-digit seven-segment display driver directly. Converts score-event pulses from game logic into per-digit values and digit enables with leading-zero blanking. Sits between the game FSM, which supplies tick/freeze/clear, and the display driver, which consumes the digit and enable outputs.

## Interface
- TICKS_PER_POINT, default 1: score ticks accepted per +1 score increment; legal range 1..255.
- clk_i  in  1  system clock; one clock domain.
- rst_ni  in  1  reset, synchronous, active-low.
- tick_i  in  1  single-cycle score event pulse.
- freeze_i  in  1  game-over pulse: stop counting, commit high score.
- clear_i  in  1  new-game pulse: zero score and resume counting.
- show_high_i  in  1  level: display high score instead of current score.
- digit0_en_o..digit3_en_o  out  1 each  digit enable; digit0 is least significant.
- digit0_o..digit3_o  out  4 each  BCD digit value, 0..9.
- score_bcd_o  out  16  current score {d3,d2,d1,d0}.
- high_bcd_o  out  16  stored high score.
- sat_o  out  1  score is saturated at 9999.
- running_o  out  1  high in RUN state.

## Operation
- FSM states: RUN and FROZEN. Reset state is RUN.
- Priority within a cycle: clear_i > freeze_i > tick_i.
- clear_i in any state: score := 0, prescaler := 0, state := RUN. High score is unchanged. No high-score commit.
- freeze_i in RUN: state := FROZEN. If score > high, high := score. Any tick_i in the same cycle is dropped.
- freeze_i in FROZEN: ignored.
- tick_i in RUN, not saturated:
  - Prescaler increments.
  - When the prescaler reaches TICKS_PER_POINT-1, it wraps to 0 and the score increments by 1.
- tick_i in FROZEN: ignored.
- BCD increment: digit n wraps 9→0 and carries into digit n+1.
- At 9999 the score holds, sat_o=1, and further ticks are ignored. The prescaler also holds.
- BCD comparison is digit-wise, most significant digit first; equivalent to a binary compare of the 16-bit value.
- Display source is the high score when show_high_i=1, otherwise the current score.
- Leading-zero blanking on the displayed value:
  - digit3_en_o = (d3≠0)
  - digit2_en_o = (d3|d2≠0)
  - digit1_en_o = (d3|d2|d1≠0)
  - digit0_en_o = 1 always
  - Blanked digits still drive their value (0).

## Timing
- Reset values: score 0, high 0, prescaler 0, state RUN, running_o=1, sat_o=0, digit*_o=0, digit0_en_o=1, digit1..3_en_o=0.
- Score, high, prescaler and state registers update on the clk_i edge where the event is sampled.
- All outputs are combinational from registers plus show_high_i. Event-to-output latency is 1 cycle. show_high_i-to-output latency is 0 cycles.
- Reset mid-game clears everything, including the high score. Reset has priority over all inputs.
- Back-to-back ticks on consecutive cycles are all counted, with no dead cycles.

## Configuration
- DINO_HIGH_SCORE_EN defined: high-score register, commit on freeze, and show_high_i mux are all present.
- DINO_HIGH_SCORE_EN undefined:
  - No high-score register.
  - high_bcd_o tied to 0.
  - show_high_i ignored; the current score is always displayed.
  - freeze_i only changes state.

## Structure
- Shared package dino_pkg holds:
  - typedef bcd4_t (4×logic[3:0] packed);
  - enum score_state_e {RUN, FROZEN};
  - constant SCORE_MAX_BCD = 16'h9999.
- Sub-module bcd_incr: combinational 4-digit BCD +1 with carry-out, used for the score increment. Saturation detection uses the carry-out.
- Blanking and display mux stay in the top module.

## Test plan
- Reset, then 12 ticks with TICKS_PER_POINT=1 → score_bcd_o=16'h0012; digit1_en_o=1, digit2_en_o=0, digit3_en_o=0.
- TICKS_PER_POINT=4, 9 ticks → score 2, prescaler 1. Then clear_i → score 0, and the next 4 ticks give score 1.
- Drive score to 0999, then 1 tick → 1000 with all enables=1. Load 9998, then 3 ticks → 9999 with sat_o=1.
- Score 0150, freeze_i with tick_i in the same cycle → state FROZEN, score stays 0150, high=0150. A later tick has no effect. With show_high_i=1 the display shows 150.
- Clear, count to 0042, freeze → high stays 0150. Clear and tick_i in the same cycle → score 0, running_o=1.
- Build without DINO_HIGH_SCORE_EN: freeze after score 5 → high_bcd_o=0, and show_high_i=1 still displays 5.
